sync_memory: RTL and testbench

Clocked, parametrised successor to the asynchronous byte-wide SRAM model: a single-port word memory with byte-lane write enables, a req/ack handshake, a programmable number of wait states, and a hardware bulk-clear sequencer. It sits between the core bus logic and main memory, where it models wait-stated RAM and gives the bus controller a deterministic completion signal.

---
 rtl/sync_memory_pkg.sv | 18 +
 rtl/sync_memory_mem_array.sv | 42 ++++
 rtl/sync_memory.sv | 152 +++++++++++++++
 tb/tb_sync_memory.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_memory_pkg.sv
// Shared types and helpers for the wait-stated word memory and its storage array.
// Holds the controller state encoding, wait counter width and lane-count helper.
package sol1_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ACK   = 2'd2,
    CLEAR = 2'd3
  } mem_state_t;

  localparam int WS_W = 4;

  function automatic int lanes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/sync_memory_mem_array.sv
// Plain word storage with per-lane synchronous write and registered read.
// Latency: write and read both take effect on the enabling edge; no backpressure.
// Out-of-range addresses drop writes and read back zero.
module mem_array
  import sol1_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_SIZE   = 65536
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic                         rd_en,
  input  logic [$clog2(MEM_SIZE)-1:0]  addr,
  input  logic [lanes(DATA_WIDTH)-1:0] be,
  input  logic [DATA_WIDTH-1:0]        wdata,
  output logic [DATA_WIDTH-1:0]        rdata
);

  localparam int AW    = $clog2(MEM_SIZE);
  localparam int LANES = lanes(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [0:MEM_SIZE-1];
  logic                  in_range;

  assign in_range = ({{(32-AW){1'b0}}, addr} < 32'(MEM_SIZE));

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_en && in_range) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rdata <= '0;
    else if (rd_en)  rdata <= in_range ? mem[addr] : '0;
  end

endmodule

// File: rtl/sync_memory.sv
// Single-port word memory with req/ack handshake, wait states and bulk clear.
// Latency: ack in the cycle 1+WAIT_STATES after acceptance; clear_done MEM_SIZE+1 after clear.
// Backpressure: req/clear are only sampled in IDLE; busy is high everywhere else.
module sync_memory
  import sol1_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_SIZE    = 65536,
  parameter int WAIT_STATES = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req,
  input  logic                         we,
  input  logic [$clog2(MEM_SIZE)-1:0]  addr,
  input  logic [lanes(DATA_WIDTH)-1:0] be,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic                         clear,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic                         ack,
  output logic                         busy,
  output logic                         clear_done
);

  localparam int AW    = $clog2(MEM_SIZE);
  localparam int LANES = lanes(DATA_WIDTH);
  localparam logic [WS_W-1:0] WS_LOAD = (WAIT_STATES > 0) ? WS_W'(WAIT_STATES - 1) : '0;
  localparam logic [AW-1:0]   LAST    = AW'(MEM_SIZE - 1);

  mem_state_t            state_q, state_d;
  logic [AW-1:0]         addr_q;
  logic                  we_q;
  logic [LANES-1:0]      be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [WS_W-1:0]       ws_q, ws_d;
  logic [AW-1:0]         clr_q, clr_d;
  logic                  fin_q, fin_d;
  logic                  cap_en;

  logic                  mem_wr, mem_rd;
  logic [AW-1:0]         mem_addr;
  logic [LANES-1:0]      mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      ws_q    <= '0;
      clr_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ws_q    <= ws_d;
      clr_q   <= clr_d;
      fin_q   <= fin_d;
      if (cap_en) begin
        addr_q  <= addr;
        we_q    <= we;
        be_q    <= be;
        wdata_q <= wdata;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ws_d       = ws_q;
    clr_d      = clr_q;
    fin_d      = fin_q;
    cap_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_rd     = 1'b0;
    mem_addr   = addr_q;
    mem_be     = be_q;
    mem_wdata  = wdata_q;
    ack        = 1'b0;
    clear_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          clr_d   = '0;
          fin_d   = 1'b0;
        end else if (req) begin
          cap_en = 1'b1;
          if (WAIT_STATES == 0) begin
            // Zero wait states: commit straight from the live inputs on acceptance.
            state_d   = ACK;
            mem_addr  = addr;
            mem_be    = be;
            mem_wdata = wdata;
            mem_wr    = we;
            mem_rd    = !we;
          end else begin
            state_d = WAIT;
            ws_d    = WS_LOAD;
          end
        end
      end
      WAIT: begin
        if (ws_q == '0) begin
          state_d = ACK;
          mem_wr  = we_q;
          mem_rd  = !we_q;
        end else begin
          ws_d = ws_q - 1'b1;
        end
      end
      ACK: begin
        ack     = 1'b1;
        state_d = IDLE;
      end
      CLEAR: begin
        // One extra cycle after the last word carries clear_done, keeping busy high.
        if (fin_q) begin
          clear_done = 1'b1;
          fin_d      = 1'b0;
          state_d    = IDLE;
        end else begin
          mem_addr  = clr_q;
          mem_be    = '1;
          mem_wdata = '0;
          mem_wr    = 1'b1;
          if (clr_q == LAST) fin_d = 1'b1;
          else               clr_d = clr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_SIZE   (MEM_SIZE)
  ) u_mem_array (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (mem_wr),
    .rd_en (mem_rd),
    .addr  (mem_addr),
    .be    (mem_be),
    .wdata (mem_wdata),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_sync_memory.sv
// Two memories (MEM_SIZE 10, 16-bit words): index 0 with no wait states, index 1 with three.
module tb_sync_memory;

  typedef struct {
    int          d;
    bit          w;
    logic [3:0]  a;
    logic [1:0]  b;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    bit          rd;
    logic [15:0] exp;
  } sb_t;

  logic        clk;
  logic        rst_n      [2];
  logic        req        [2];
  logic        we         [2];
  logic [3:0]  addr       [2];
  logic [1:0]  be         [2];
  logic [15:0] wdata      [2];
  logic        clear      [2];
  logic [15:0] rdata      [2];
  logic        ack        [2];
  logic        busy       [2];
  logic        clear_done [2];

  int   n_vec = 0;
  int   n_err = 0;
  sb_t  sb_q[$];
  vec_t vecs[16];

  sync_memory #(.DATA_WIDTH(16), .MEM_SIZE(10), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .be(be[0]), .wdata(wdata[0]), .clear(clear[0]), .rdata(rdata[0]),
    .ack(ack[0]), .busy(busy[0]), .clear_done(clear_done[0])
  );

  sync_memory #(.DATA_WIDTH(16), .MEM_SIZE(10), .WAIT_STATES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .be(be[1]), .wdata(wdata[1]), .clear(clear[1]), .rdata(rdata[1]),
    .ack(ack[1]), .busy(busy[1]), .clear_done(clear_done[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic access(input int d, input bit w, input logic [3:0] a, input logic [1:0] b,
                        input logic [15:0] wd, input logic [15:0] exp);
    int  lat;
    int  bcnt;
    sb_t e;
    req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    sb_q.push_back('{rd: !w, exp: exp});
    @(posedge clk); #1;
    req[d] = 1'b0; addr[d] = ~a; be[d] = ~b; wdata[d] = ~wd;
    lat = 0; bcnt = 0;
    while (ack[d] !== 1'b1 && lat < 40) begin
      if (busy[d] === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy[d] === 1'b1) bcnt++;
    chk("ack_latency", 32'(lat), 32'(ws_of(d)));
    chk("busy_cycles", 32'(bcnt), 32'(ws_of(d) + 1));
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.rd) chk("rdata", 32'(rdata[d]), 32'(e.exp));
    end
    @(posedge clk); #1;
    chk("ack_pulse", 32'(ack[d]), 32'd0);
    chk("busy_fall", 32'(busy[d]), 32'd0);
    if (!w) chk("rdata_hold", 32'(rdata[d]), 32'(exp));
  endtask

  task automatic do_clear(input int d, input bit with_req);
    int n;
    int bcnt;
    int acks;
    clear[d] = 1'b1; req[d] = with_req; we[d] = 1'b1; addr[d] = 4'd2; be[d] = 2'b11;
    wdata[d] = 16'hFFFF;
    @(posedge clk); #1;
    clear[d] = 1'b0; req[d] = 1'b0;
    n = 0; bcnt = 0; acks = 0;
    while (clear_done[d] !== 1'b1 && n < 40) begin
      if (busy[d] === 1'b1) bcnt++;
      if (ack[d] === 1'b1) acks++;
      @(posedge clk); #1;
      n++;
    end
    if (busy[d] === 1'b1) bcnt++;
    chk("clear_done_latency", 32'(n), 32'd10);
    chk("clear_busy_cycles", 32'(bcnt), 32'd11);
    chk("clear_no_ack", 32'(acks), 32'd0);
    @(posedge clk); #1;
    chk("clear_done_pulse", 32'(clear_done[d]), 32'd0);
    chk("clear_busy_fall", 32'(busy[d]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int acks;
    clk = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0;
      be[d] = '0; wdata[d] = '0; clear[d] = 1'b0;
    end

    vecs[0]  = '{0, 1'b1, 4'd3,  2'b11, 16'hBEEF, 16'h0000};
    vecs[1]  = '{0, 1'b0, 4'd3,  2'b00, 16'h0000, 16'hBEEF};
    vecs[2]  = '{0, 1'b1, 4'd3,  2'b01, 16'h1234, 16'h0000};
    vecs[3]  = '{0, 1'b0, 4'd3,  2'b11, 16'h0000, 16'hBE34};
    vecs[4]  = '{0, 1'b0, 4'd2,  2'b00, 16'h0000, 16'h0000};
    vecs[5]  = '{0, 1'b1, 4'd2,  2'b11, 16'hCAFE, 16'h0000};
    vecs[6]  = '{0, 1'b1, 4'd12, 2'b11, 16'h00AA, 16'h0000};
    vecs[7]  = '{0, 1'b0, 4'd12, 2'b00, 16'h0000, 16'h0000};
    vecs[8]  = '{0, 1'b0, 4'd2,  2'b00, 16'h0000, 16'hCAFE};
    vecs[9]  = '{0, 1'b1, 4'd9,  2'b10, 16'h7755, 16'h0000};
    vecs[10] = '{0, 1'b0, 4'd9,  2'b00, 16'h0000, 16'h7700};
    vecs[11] = '{1, 1'b1, 4'd5,  2'b11, 16'h5A5A, 16'h0000};
    vecs[12] = '{1, 1'b0, 4'd5,  2'b00, 16'h0000, 16'h5A5A};
    vecs[13] = '{1, 1'b1, 4'd0,  2'b10, 16'hABCD, 16'h0000};
    vecs[14] = '{1, 1'b0, 4'd0,  2'b00, 16'h0000, 16'hAB00};
    vecs[15] = '{1, 1'b0, 4'd15, 2'b00, 16'h0000, 16'h0000};

    #12;
    for (int d = 0; d < 2; d++) begin
      chk("reset_ack", 32'(ack[d]), 32'd0);
      chk("reset_busy", 32'(busy[d]), 32'd0);
      chk("reset_clear_done", 32'(clear_done[d]), 32'd0);
      chk("reset_rdata", 32'(rdata[d]), 32'd0);
    end
    @(posedge clk); #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge clk); #1;

    // Clear with a simultaneous write request: the write must be dropped.
    do_clear(0, 1'b1);
    do_clear(1, 1'b0);

    for (int i = 0; i < 16; i++)
      access(vecs[i].d, vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].wd, vecs[i].exp);

    // req held high through ACK is re-accepted in the next IDLE cycle.
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 4'd3;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("b2b_ack", 32'(ack[0]), (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k % 2 == 0) chk("b2b_rdata", 32'(rdata[0]), 32'h0000BE34);
    end
    req[0] = 1'b0;
    @(posedge clk); #1;
    chk("b2b_idle_ack", 32'(ack[0]), 32'd0);
    chk("b2b_idle_busy", 32'(busy[0]), 32'd0);

    // Reset during WAIT of a write abandons it without touching memory.
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 4'd5; be[1] = 2'b11; wdata[1] = 16'h1111;
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy[1]), 32'd0);
    chk("rst_mid_ack", 32'(ack[1]), 32'd0);
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (ack[1] === 1'b1) acks++;
    end
    chk("rst_mid_no_ack", 32'(acks), 32'd0);
    access(1, 1'b0, 4'd5, 2'b00, 16'h0000, 16'h5A5A);

    // A second clear wipes previously written words.
    do_clear(0, 1'b0);
    for (int a = 0; a < 10; a++) access(0, 1'b0, 4'(a), 2'b00, 16'h0000, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
